// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Optional feature macro used by the top: HAZARD_PERF_EN (stall-cycle counter).
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    // Multiply/divide timer states; the timer's count is the state register.
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    // RAW check for one D operand against the producers sitting in E and M.
    function automatic logic operand_hazard(
        input logic [4:0] ra,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (ra != REG_ZERO) && (tuse != TUSE_NONE) &&
               (((e_wa == ra) && (e_tnew > tuse)) ||
                ((m_wa == ra) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Busy timer for the multiply/divide unit: loads on a start while idle and
// counts down to zero; a nonzero count means the unit is busy.
module pipe_hazard_ctrl_md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    output logic             md_busy,
    output logic [CNT_W-1:0] cnt
);

    logic [0:0] state;

    always_comb begin
        state = (cnt == '0) ? MD_IDLE : MD_BUSY;
    end

    // A start while busy is ignored: the decode-side stall keeps it from
    // ever reaching E in a legal program.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == MD_IDLE) begin
            if (start) begin
                cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler beside the decode stage: RAW hazards by Tuse/Tnew and
// multiply/divide busy blocking. Define HAZARD_PERF_EN to build the stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_rs_tuse,
    input  logic [1:0]  d_rt_tuse,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    output logic        stall_pc_f,
    output logic        stall_fd,
    output logic        flush_de,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    logic [CNT_W-1:0] md_cnt;
    logic             rs_stall;
    logic             rt_stall;
    logic             md_stall;
    logic             stall;

    pipe_hazard_ctrl_md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (e_md_start),
        .is_div  (e_md_is_div),
        .md_busy (md_busy),
        .cnt     (md_cnt)
    );

    // Purely combinational so the hold/bubble lands on this cycle's edge.
    always_comb begin
        rs_stall = operand_hazard(d_rs, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
        rt_stall = operand_hazard(d_rt, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
        md_stall = d_is_md && ((md_cnt != '0) || e_md_start);
        stall    = rs_stall || rt_stall || md_stall;
    end

    assign stall_pc_f = stall;
    assign stall_fd   = stall;
    assign flush_de   = stall;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic against a cycle-indexed behavioural model.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_is_div;
    logic        stall_pc_f, stall_fd, flush_de, md_busy;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: md busy during absolute cycles [b_lo, b_hi]; scount = stall cycles.
    int          cyc = 0;
    int          b_lo = 1;
    int          b_hi = 0;
    logic [31:0] scount = 32'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_rs_tuse   (d_rs_tuse),
        .d_rt_tuse   (d_rt_tuse),
        .d_is_md     (d_is_md),
        .e_wa        (e_wa),
        .e_tnew      (e_tnew),
        .m_wa        (m_wa),
        .m_tnew      (m_tnew),
        .e_md_start  (e_md_start),
        .e_md_is_div (e_md_is_div),
        .stall_pc_f  (stall_pc_f),
        .stall_fd    (stall_fd),
        .flush_de    (flush_de),
        .md_busy     (md_busy),
        .stall_count (stall_count)
    );

    function automatic bit exp_busy();
        return (cyc >= b_lo) && (cyc <= b_hi);
    endfunction

    function automatic bit reads_stale(input logic [4:0] r, input logic [1:0] tuse);
        int need;
        int e_ready;
        int m_ready;
        if (r == 5'd0 || tuse == 2'd3) return 1'b0;
        need    = int'(tuse);
        e_ready = int'(e_tnew);
        m_ready = int'(m_tnew);
        return (e_wa == r && e_ready > need) || (m_wa == r && m_ready > need);
    endfunction

    function automatic bit exp_stall();
        return reads_stale(d_rs, d_rs_tuse) || reads_stale(d_rt, d_rt_tuse) ||
               (d_is_md && (exp_busy() || e_md_start));
    endfunction

    task automatic clear_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
        d_is_md = 1'b0; e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
        e_md_start = 1'b0; e_md_is_div = 1'b0;
    endtask

    // One clock edge; advances the model with the inputs seen at that edge.
    task automatic tick();
        bit s, b;
        s = exp_stall();
        b = exp_busy();
        @(posedge clk);
        if (reset) begin
            b_lo = 1; b_hi = 0; scount = 32'd0;
        end else begin
            if (s && PERF && scount != 32'hFFFF_FFFF) scount = scount + 32'd1;
            if (e_md_start && !b) begin
                b_lo = cyc + 1;
                b_hi = cyc + (e_md_is_div ? 10 : 5);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (stall_pc_f !== 1'b0) begin n_bad++; $display("FAIL reset_stall_pc_f: got %b want 0", stall_pc_f); end
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL reset_stall_fd: got %b want 0", stall_fd); end
        n_cmp++; if (flush_de !== 1'b0) begin n_bad++; $display("FAIL reset_flush_de: got %b want 0", flush_de); end
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        n_cmp++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
        tick();
    endtask

    task automatic test_raw();
        clear_inputs();
        e_wa = 5'd8; e_tnew = 2'd1; d_rs = 5'd8; d_rs_tuse = 2'd0;
        #1;
        n_cmp++; if (stall_pc_f !== 1'b1) begin n_bad++; $display("FAIL raw_e_rs: got %b want 1", stall_pc_f); end
        n_cmp++; if (flush_de !== 1'b1) begin n_bad++; $display("FAIL raw_e_rs_flush: got %b want 1", flush_de); end
        tick();
        e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd8; m_tnew = 2'd0;
        #1;
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL raw_m_ready: got %b want 0", stall_fd); end
        tick();
        e_wa = 5'd8; e_tnew = 2'd1; m_wa = 5'd0; d_rs_tuse = 2'd1;
        #1;
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL raw_tuse_eq_tnew: got %b want 0", stall_fd); end
        tick();
        e_wa = 5'd0; d_rs = 5'd0; d_rs_tuse = 2'd0; e_tnew = 2'd2;
        #1;
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL raw_reg0: got %b want 0", stall_fd); end
        tick();
        clear_inputs();
        d_rt = 5'd9; d_rt_tuse = 2'd1; m_wa = 5'd9; m_tnew = 2'd2;
        #1;
        n_cmp++; if (stall_pc_f !== 1'b1) begin n_bad++; $display("FAIL raw_m_rt: got %b want 1", stall_pc_f); end
        tick();
        d_rt_tuse = 2'd3;
        #1;
        n_cmp++; if (stall_pc_f !== 1'b0) begin n_bad++; $display("FAIL raw_tuse_none: got %b want 0", stall_pc_f); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mult();
        clear_inputs();
        e_md_start = 1'b1; d_is_md = 1'b1;
        #1;
        n_cmp++; if (stall_fd !== 1'b1) begin n_bad++; $display("FAIL mult_start_stall: got %b want 1", stall_fd); end
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL mult_start_busy: got %b want 0", md_busy); end
        tick();
        e_md_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_cmp++; if (md_busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy_t%0d: got %b want 1", k, md_busy); end
            n_cmp++; if (stall_fd !== 1'b1) begin n_bad++; $display("FAIL mult_stall_t%0d: got %b want 1", k, stall_fd); end
            tick();
        end
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL mult_release_busy: got %b want 0", md_busy); end
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL mult_release_stall: got %b want 0", stall_fd); end
        tick();
        clear_inputs();
    endtask

    task automatic test_div();
        int highs;
        highs = 0;
        clear_inputs();
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        tick();
        e_md_start = 1'b0; e_md_is_div = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            e_md_start = (i == 4);
            #1;
            if (md_busy === 1'b1) highs++;
            n_cmp++; if (md_busy !== (i <= 10)) begin n_bad++; $display("FAIL div_busy_t%0d: got %b want %b", i, md_busy, (i <= 10)); end
            tick();
        end
        n_cmp++; if (highs != 10) begin n_bad++; $display("FAIL div_busy_len: got %0d want 10", highs); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        tick();
        clear_inputs();
        d_is_md = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if (stall_fd !== 1'b1) begin n_bad++; $display("FAIL rst_div_pre_stall: got %b want 1", stall_fd); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL rst_div_busy: got %b want 0", md_busy); end
        n_cmp++; if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL rst_div_stall: got %b want 0", stall_fd); end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall_count();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_wa = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_rs_tuse = 2'd1;
            tick();
            clear_inputs();
            tick();
        end
        #1;
        n_cmp++; if (stall_count !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL stall_count_three: got %0d want %0d", stall_count, (PERF ? 3 : 0)); end
        n_cmp++; if (stall_count !== scount) begin n_bad++; $display("FAIL stall_count_model: got %0d want %0d", stall_count, scount); end
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            d_rs        = 5'($urandom_range(0, 3));
            d_rt        = 5'($urandom_range(0, 3));
            d_rs_tuse   = 2'($urandom_range(0, 3));
            d_rt_tuse   = 2'($urandom_range(0, 3));
            e_wa        = 5'($urandom_range(0, 3));
            m_wa        = 5'($urandom_range(0, 3));
            e_tnew      = 2'($urandom_range(0, 3));
            m_tnew      = 2'($urandom_range(0, 3));
            d_is_md     = ($urandom_range(0, 2) == 0);
            e_md_start  = ($urandom_range(0, 7) == 0);
            e_md_is_div = $urandom_range(0, 1) == 1;
            #1;
            s = exp_stall();
            n_cmp++; if (stall_pc_f !== s) begin n_bad++; $display("FAIL rnd_stall_pc_f c%0d: got %b want %b", cyc, stall_pc_f, s); end
            n_cmp++; if (stall_fd !== s) begin n_bad++; $display("FAIL rnd_stall_fd c%0d: got %b want %b", cyc, stall_fd, s); end
            n_cmp++; if (flush_de !== s) begin n_bad++; $display("FAIL rnd_flush_de c%0d: got %b want %b", cyc, flush_de, s); end
            n_cmp++; if (md_busy !== exp_busy()) begin n_bad++; $display("FAIL rnd_md_busy c%0d: got %b want %b", cyc, md_busy, exp_busy()); end
            n_cmp++; if (stall_count !== scount) begin n_bad++; $display("FAIL rnd_stall_count c%0d: got %0d want %0d", cyc, stall_count, scount); end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_raw();
        test_mult();
        test_div();
        test_reset_mid_div();
        test_stall_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
